// File: rtl/fifo_read_scheduler.sv
// Frame FIFO read scheduler: pops one entry per frame, validates it, and
// streams its 16-bit words to a single one-hot selected channel.
module fifo_read_scheduler #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         fifo_empty,
  output logic         fifo_r_enable,
  input  logic [139:0] fifo_data,
  input  logic [7:0]   ch_ready,
  output logic [7:0]   ch_valid,
  output logic [15:0]  dout,
  output logic         frame_last,
  output logic         fmt_err,
  output logic         timeout_err,
  output logic         busy
);

  localparam int unsigned SW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    LOAD,
    SEND
  } state_t;

  state_t         state;
  logic [127:0]   payload;
  logic [7:0]     ch_reg;
  logic [3:0]     remaining;
  logic [SW-1:0]  stall_cnt;

  logic [7:0]     ld_ch;
  logic [3:0]     ld_n;
  logic           ld_ok;
  logic           xfer;

  always_comb begin
    ld_ch = fifo_data[11:4];
    ld_n  = fifo_data[3:0];
    ld_ok = (ld_ch != '0) && ((ld_ch & (ld_ch - 8'd1)) == '0) &&
            (ld_n != '0) && (ld_n <= 4'd8);
    xfer  = (state == SEND) && ((ch_reg & ch_ready) != '0);
  end

  assign busy = (state != IDLE);

  // dout always mirrors the top word of payload while in SEND, so on a
  // transfer it is loaded with the word that becomes the new top.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fifo_r_enable <= 1'b0;
      payload       <= '0;
      ch_reg        <= '0;
      remaining     <= '0;
      stall_cnt     <= '0;
      ch_valid      <= '0;
      dout          <= '0;
      frame_last    <= 1'b0;
      fmt_err       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      fifo_r_enable <= 1'b0;
      fmt_err       <= 1'b0;
      timeout_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_r_enable <= 1'b1;
            state         <= POP;
          end
        end
        POP: state <= LOAD;
        LOAD: begin
          payload   <= fifo_data[139:12];
          ch_reg    <= ld_ch;
          remaining <= ld_n;
          stall_cnt <= '0;
          if (ld_ok) begin
            ch_valid   <= ld_ch;
            dout       <= fifo_data[139:124];
            frame_last <= (ld_n == 4'd1);
            state      <= SEND;
          end else begin
            fmt_err <= 1'b1;
            state   <= IDLE;
          end
        end
        SEND: begin
          if (xfer) begin
            stall_cnt <= '0;
            payload   <= payload << 16;
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) begin
              ch_valid   <= '0;
              dout       <= '0;
              frame_last <= 1'b0;
              state      <= IDLE;
            end else begin
              dout       <= payload[111:96];
              frame_last <= (remaining == 4'd2);
            end
          end else if (stall_cnt == STALL_MAX) begin
            timeout_err <= 1'b1;
            stall_cnt   <= '0;
            remaining   <= '0;
            ch_valid    <= '0;
            dout        <= '0;
            frame_last  <= 1'b0;
            state       <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Directed bench for fifo_read_scheduler with a behavioural one-cycle-latency
// frame FIFO; outputs are sampled on the falling clock edge.
module tb_fifo_read_scheduler;

  localparam int unsigned TO = 16;

  logic         clk_in = 1'b0;
  logic         rst_n  = 1'b0;
  logic         fifo_empty = 1'b1;
  logic         fifo_r_enable;
  logic [139:0] fifo_data = '0;
  logic [7:0]   ch_ready = '0;
  logic [7:0]   ch_valid;
  logic [15:0]  dout;
  logic         frame_last;
  logic         fmt_err;
  logic         timeout_err;
  logic         busy;

  logic [139:0] q[$];
  int           pops = 0;
  logic         pop_en;
  int           n_assert = 0;
  int           n_fail = 0;

  fifo_read_scheduler #(.TIMEOUT(TO)) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_r_enable(fifo_r_enable),
    .fifo_data    (fifo_data),
    .ch_ready     (ch_ready),
    .ch_valid     (ch_valid),
    .dout         (dout),
    .frame_last   (frame_last),
    .fmt_err      (fmt_err),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  always #5 clk_in = ~clk_in;

  // Popped data is presented for exactly the cycle after the pop, garbage otherwise.
  always @(posedge clk_in) begin
    pop_en = fifo_r_enable;
    #1;
    if (pop_en && q.size() > 0) begin
      fifo_data = q.pop_front();
      pops++;
    end else begin
      fifo_data = {12'h0, $urandom, $urandom, $urandom, $urandom};
    end
    fifo_empty = (q.size() == 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [139:0] mk(input logic [127:0] pl, input logic [7:0] ch,
                                      input logic [3:0] n);
    return {pl, ch, n};
  endfunction

  task automatic wait_pop(input string tag);
    int k = 0;
    @(negedge clk_in);
    while (!fifo_r_enable && k < 20) begin
      @(negedge clk_in);
      k++;
    end
    chk(tag, {31'd0, fifo_r_enable}, 32'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_chv"}, {24'd0, ch_valid}, 32'd0);
    chk({tag, "_dout"}, {16'd0, dout}, 32'd0);
    chk({tag, "_last"}, {31'd0, frame_last}, 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    int p0;

    // Reset state
    repeat (3) @(negedge clk_in);
    chk_quiet("rst");
    chk("rst_ren", {31'd0, fifo_r_enable}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_errs", {30'd0, fmt_err, timeout_err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("idle_ren", {31'd0, fifo_r_enable}, 32'd0);

    // Basic two-word frame on channel 2
    ch_ready = 8'hFF;
    q.push_back(mk({16'hA1B2, 16'hC3D4, 96'h0}, 8'h04, 4'd2));
    wait_pop("b_pop");
    chk("b_pop_busy", {31'd0, busy}, 32'd1);
    @(negedge clk_in);
    chk("b_load_chv", {24'd0, ch_valid}, 32'd0);
    @(negedge clk_in);
    chk("b_w1_chv", {24'd0, ch_valid}, 32'h04);
    chk("b_w1_dout", {16'd0, dout}, 32'hA1B2);
    chk("b_w1_last", {31'd0, frame_last}, 32'd0);
    @(negedge clk_in);
    chk("b_w2_dout", {16'd0, dout}, 32'hC3D4);
    chk("b_w2_last", {31'd0, frame_last}, 32'd1);
    @(negedge clk_in);
    chk_quiet("b_end");
    chk("b_end_busy", {31'd0, busy}, 32'd0);

    // Eight words with toggling ready; other channels' ready must be ignored
    ch_ready = 8'hFE;
    q.push_back(mk({16'h1111, 16'h2222, 16'h3333, 16'h4444,
                    16'h5555, 16'h6666, 16'h7777, 16'h8888}, 8'h01, 4'd8));
    wait_pop("t_pop");
    @(negedge clk_in);
    @(negedge clk_in);
    for (int i = 1; i <= 8; i++) begin
      w = {4'(i), 4'(i), 4'(i), 4'(i)};
      chk($sformatf("t_w%0d_chv", i), {24'd0, ch_valid}, 32'h01);
      chk($sformatf("t_w%0d_dout", i), {16'd0, dout}, {16'd0, w});
      chk($sformatf("t_w%0d_last", i), {31'd0, frame_last}, {31'd0, i == 8});
      ch_ready = 8'hFE;
      @(negedge clk_in);
      chk($sformatf("t_w%0d_hold", i), {15'd0, ch_valid[0], dout}, {15'd0, 1'b1, w});
      ch_ready = 8'h01;
      @(negedge clk_in);
    end
    chk_quiet("t_end");

    // Malformed entries followed by a good one
    ch_ready = 8'hFF;
    q.push_back(mk({16'hDEAD, 112'h0}, 8'h05, 4'd2));
    q.push_back(mk({16'hBEEF, 112'h0}, 8'h10, 4'd9));
    q.push_back(mk({16'h5A5A, 16'hFFFF, 96'h0}, 8'h02, 4'd1));
    wait_pop("f1_pop");
    @(negedge clk_in);
    @(negedge clk_in);
    chk("f1_err", {31'd0, fmt_err}, 32'd1);
    chk("f1_chv", {24'd0, ch_valid}, 32'd0);
    chk("f1_busy", {31'd0, busy}, 32'd0);
    wait_pop("f2_pop");
    chk("f1_err_pulse", {31'd0, fmt_err}, 32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("f2_err", {31'd0, fmt_err}, 32'd1);
    chk("f2_chv", {24'd0, ch_valid}, 32'd0);
    wait_pop("f3_pop");
    chk("f2_err_pulse", {31'd0, fmt_err}, 32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("f3_chv", {24'd0, ch_valid}, 32'h02);
    chk("f3_dout", {16'd0, dout}, 32'h5A5A);
    chk("f3_last", {31'd0, frame_last}, 32'd1);
    chk("f3_noerr", {31'd0, fmt_err}, 32'd0);
    @(negedge clk_in);
    chk_quiet("f3_end");

    // Stall timeout on channel 7, then the next entry is served
    ch_ready = 8'h7F;
    q.push_back(mk({16'h0A0A, 16'h0B0B, 16'h0C0C, 80'h0}, 8'h80, 4'd3));
    q.push_back(mk({16'h1234, 112'h0}, 8'h08, 4'd1));
    wait_pop("to_pop");
    @(negedge clk_in);
    @(negedge clk_in);
    chk("to_chv0", {24'd0, ch_valid}, 32'h80);
    repeat (TO - 1) @(negedge clk_in);
    chk("to_pre_chv", {24'd0, ch_valid}, 32'h80);
    chk("to_pre_err", {31'd0, timeout_err}, 32'd0);
    @(negedge clk_in);
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    chk_quiet("to_drop");
    ch_ready = 8'hFF;
    wait_pop("to_next_pop");
    chk("to_err_pulse", {31'd0, timeout_err}, 32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("to_next_chv", {24'd0, ch_valid}, 32'h08);
    chk("to_next_dout", {16'd0, dout}, 32'h1234);
    @(negedge clk_in);

    // Back-to-back frames: one idle cycle between last transfer and next pop
    p0 = pops;
    q.push_back(mk({16'hAAAA, 16'hBBBB, 96'h0}, 8'h02, 4'd2));
    q.push_back(mk({16'hCCCC, 112'h0}, 8'h40, 4'd1));
    wait_pop("bb_pop1");
    @(negedge clk_in);
    @(negedge clk_in);
    chk("bb_w1", {16'd0, dout}, 32'hAAAA);
    @(negedge clk_in);
    chk("bb_w2", {16'd0, dout}, 32'hBBBB);
    @(negedge clk_in);
    chk("bb_gap_ren", {31'd0, fifo_r_enable}, 32'd0);
    chk("bb_gap_busy", {31'd0, busy}, 32'd0);
    @(negedge clk_in);
    chk("bb_pop2", {31'd0, fifo_r_enable}, 32'd1);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("bb_w3_chv", {24'd0, ch_valid}, 32'h40);
    chk("bb_w3", {16'd0, dout}, 32'hCCCC);
    @(negedge clk_in);
    chk("bb_pops", pops - p0, 32'd2);

    // Asynchronous reset during word 2 of a four-word frame
    q.push_back(mk({16'h1010, 16'h2020, 16'h3030, 16'h4040, 64'h0}, 8'h04, 4'd4));
    wait_pop("r_pop");
    @(negedge clk_in);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("r_w2", {16'd0, dout}, 32'h2020);
    #2 rst_n = 1'b0;
    #1;
    chk_quiet("r_async");
    chk("r_async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    p0 = pops;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      chk($sformatf("r_after%0d", i), {23'd0, fifo_r_enable, ch_valid}, 32'd0);
    end
    q.push_back(mk({16'hBEEF, 112'h0}, 8'h01, 4'd1));
    wait_pop("r_next_pop");
    @(negedge clk_in);
    @(negedge clk_in);
    chk("r_next_chv", {24'd0, ch_valid}, 32'h01);
    chk("r_next_dout", {16'd0, dout}, 32'hBEEF);
    @(negedge clk_in);
    chk("r_pops", pops - p0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
